dp_phy_lane_model: RTL and testbench



---
 rtl/dp_phy_lane_model.sv | 44 ++++
 tb/tb_dp_phy_lane_model.sv | 104 ++++++++++
 2 files changed

// File: rtl/dp_phy_lane_model.sv
// dp_phy_lane_model: one DP PHY lane delay line with symbol skew and single-bit error injection.
module dp_phy_lane_model #(
  parameter int P_LANE = 0,
  parameter int P_DLY  = 2,
  parameter int P_SPL  = 2,
  parameter int P_SKEW = 0
) (
  input  logic                 CLK_IN,
  input  logic                 RST_IN,
  input  logic [P_SPL*11-1:0]  DAT_IN,
  input  logic                 ERR_IN,
  output logic [P_SPL*11-1:0]  DAT_OUT,
  output logic                 LOCK_OUT
);
  localparam int D = (P_DLY < 2) ? 2 : P_DLY;
  localparam int W = P_SPL * 11;
  localparam logic [4:0] L = 5'(D + ((P_SKEW > 0) ? 1 : 0));
  if (P_LANE < 0 || P_LANE > 3 || !(P_SPL == 2 || P_SPL == 4) || P_SKEW < 0 || P_SKEW >= P_SPL)
    $error("dp_phy_lane_model: illegal parameters");
  logic [W-1:0]   dly [D-1];
  logic [W-1:0]   prv, cur, cap;
  logic [2*W-1:0] cat;
  logic [4:0]     cnt;
  assign cap = DAT_IN ^ W'(ERR_IN);
  assign cur = dly[D-2];
  assign cat = {cur, prv};
  // DAT_OUT is the last delay stage, so the chain itself holds D-1 words
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      for (int i = 0; i < D - 1; i++) dly[i] <= '0;
      prv      <= '0;
      DAT_OUT  <= '0;
      cnt      <= '0;
      LOCK_OUT <= 1'b0;
    end else begin
      dly[0] <= cap;
      for (int i = 1; i < D - 1; i++) dly[i] <= dly[i-1];
      prv      <= cur;
      DAT_OUT  <= cat[(P_SPL-P_SKEW)*11 +: W];
      cnt      <= (cnt == L) ? cnt : cnt + 5'd1;
      LOCK_OUT <= LOCK_OUT | (cnt >= L - 5'd1);
    end
  end
endmodule

// File: tb/tb_dp_phy_lane_model.sv
// tb_dp_phy_lane_model: directed checks of delay, skew, error injection, reset, clamp and transparency.
module tb_dp_phy_lane_model;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [21:0] dat0 = '0, dat3 = '0, out0, out3;
  logic [43:0] dat1 = '0, dat2 = '0, dat4 = '0, out1, out2, out4;
  logic        err2 = 1'b0;
  logic        lk0, lk1, lk2, lk3, lk4;
  logic [10:0] hist [5][128];
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  dp_phy_lane_model #(.P_LANE(0), .P_DLY(2), .P_SPL(2), .P_SKEW(0)) u0 (
    .CLK_IN(clk), .RST_IN(rst), .DAT_IN(dat0), .ERR_IN(1'b0), .DAT_OUT(out0), .LOCK_OUT(lk0));
  dp_phy_lane_model #(.P_LANE(1), .P_DLY(3), .P_SPL(4), .P_SKEW(1)) u1 (
    .CLK_IN(clk), .RST_IN(rst), .DAT_IN(dat1), .ERR_IN(1'b0), .DAT_OUT(out1), .LOCK_OUT(lk1));
  dp_phy_lane_model #(.P_LANE(2), .P_DLY(4), .P_SPL(4), .P_SKEW(0)) u2 (
    .CLK_IN(clk), .RST_IN(rst), .DAT_IN(dat2), .ERR_IN(err2), .DAT_OUT(out2), .LOCK_OUT(lk2));
  dp_phy_lane_model #(.P_LANE(3), .P_DLY(1), .P_SPL(2), .P_SKEW(0)) u3 (
    .CLK_IN(clk), .RST_IN(rst), .DAT_IN(dat3), .ERR_IN(1'b0), .DAT_OUT(out3), .LOCK_OUT(lk3));
  dp_phy_lane_model #(.P_LANE(0), .P_DLY(3), .P_SPL(4), .P_SKEW(3)) u4 (
    .CLK_IN(clk), .RST_IN(rst), .DAT_IN(dat4), .ERR_IN(1'b0), .DAT_OUT(out4), .LOCK_OUT(lk4));
  function automatic logic [43:0] exp_word(int inst, int k, int spl, int d, int s);
    logic [43:0] w = '0;
    int idx;
    for (int j = 0; j < spl; j++) begin
      idx = k * spl + j - (d * spl + s);
      if (idx >= 0) w[j*11 +: 11] = hist[inst][idx];
    end
    return w;
  endfunction
  task automatic chk(input string tag, input int k, input logic [43:0] obs, input logic [43:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: got %h expected %h", tag, k, obs, exp);
    end
  endtask
  initial begin
    logic [10:0] sym;
    logic e;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 32; k++) begin
        e = (k == 10) || (r == 0 && (k == 28 || k == 29)) || (r == 1 && (k == 20 || k == 21));
        err2 = e;
        for (int j = 0; j < 2; j++) begin
          sym = 11'(k * 2 + j);
          dat0[j*11 +: 11] = sym;
          dat3[j*11 +: 11] = sym;
          hist[0][k*2+j] = sym;
        end
        for (int j = 0; j < 4; j++) begin
          sym = 11'(k * 4 + j);
          dat1[j*11 +: 11] = sym;
          hist[1][k*4+j] = sym;
          dat2[j*11 +: 11] = 11'h000;
          hist[2][k*4+j] = (j == 0 && e) ? 11'h001 : 11'h000;
          sym = 11'($urandom_range(0, 2047)) | ((k % 3 == 0) ? 11'h600 : 11'h000);
          dat4[j*11 +: 11] = sym;
          hist[4][k*4+j] = sym;
        end
        @(negedge clk);
        chk("basic_dat", k, 44'(out0), exp_word(0, k, 2, 2, 0));
        chk("basic_lock", k, 44'(lk0), 44'(k >= 2));
        chk("skew_dat", k, out1, exp_word(1, k, 4, 3, 1));
        chk("skew_lock", k, 44'(lk1), 44'(k >= 4));
        chk("err_dat", k, out2, exp_word(2, k, 4, 4, 0));
        chk("err_lock", k, 44'(lk2), 44'(k >= 4));
        chk("clamp_dat", k, 44'(out3), exp_word(0, k, 2, 2, 0));
        chk("clamp_lock", k, 44'(lk3), 44'(k >= 2));
        chk("xpar_dat", k, out4, exp_word(4, k, 4, 3, 3));
        chk("xpar_lock", k, 44'(lk4), 44'(k >= 4));
        if (k == 2) chk("basic_first_word", k, 44'(out0), 44'h800);
        if (k == 3) chk("skew_first_word", k, out1, (44'd2 << 33) | (44'd1 << 22));
        if (k == 4) chk("skew_second_word", k, out1, 44'd3 | (44'd4 << 11) | (44'd5 << 22) | (44'd6 << 33));
        if (k == 14 || k == 13 || k == 15) chk("err_pulse", k, out2, (k == 14) ? 44'h1 : 44'h0);
        @(posedge clk);
        #1;
      end
      if (r == 0) begin
        rst = 1'b1;
        err2 = 1'b1;
        dat0 = '1; dat1 = '1; dat2 = '1; dat3 = '1; dat4 = '1;
        @(negedge clk);
        chk("pre_rst_lock", 0, 44'(lk1), 44'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        err2 = 1'b0;
        @(negedge clk);
        chk("mid_rst_dat", 0, out2, 44'h0);
        chk("mid_rst_lock", 0, 44'(lk2), 44'd0);
        chk("mid_rst_skew", 0, out1, 44'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
